// File: rtl/fht_adc_loader.sv
`default_nettype none
// ============================================================================
// fht_adc_loader : ADC sample stream -> 4-bank FHT input loader with start/handshake.
// Optional FHT_LOADER_DROP_CNT_EN adds the oDROP_CNT port.   Revision: 1.0
// ============================================================================
module fht_adc_loader #(
  parameter int ADC_WIDTH = 12,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iCLR,
  input  logic                        iVALID,
  input  logic signed [ADC_WIDTH-1:0] iSAMPLE,
  output logic                        oREADY,
  output logic [3:0]                  oWE,
  output logic [D_BIT-1:0]            oDATA,
  output logic [A_BIT-1:0]            oADDR,
  output logic                        oSTART,
  input  logic                        iFHT_RDY,
  output logic                        oBUSY
`ifdef FHT_LOADER_DROP_CNT_EN
  ,
  output logic [15:0]                 oDROP_CNT
`endif
);

  localparam int C_PAD = D_BIT - ADC_WIDTH;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_KICK = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         bank_q;
  logic [A_BIT-1:0]   row_q;
  logic [3:0]         we_q;
  logic [D_BIT-1:0]   data_q;
  logic [A_BIT-1:0]   addr_q;
  logic               start_q;
  logic               busy_q;
  logic               rdy_q;

  logic               accept;
  logic               last_smp;
  logic [1:0]         bank_d;
  logic [A_BIT-1:0]   row_d;

  assign oREADY   = (state_q == S_LOAD);
  assign accept   = iVALID & oREADY & ~iCLR;
  assign last_smp = (bank_q == 2'd3) && (row_q == {A_BIT{1'b1}});
  assign bank_d   = bank_q + 2'd1;
  // The row only advances once all four banks of the current row are filled.
  assign row_d    = (bank_q == 2'd3) ? row_q + A_BIT'(1) : row_q;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= S_LOAD;
      bank_q  <= '0;
      row_q   <= '0;
      we_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q   <= iFHT_RDY;
      we_q    <= '0;
      start_q <= 1'b0;
      if (iCLR) begin
        state_q <= S_LOAD;
        bank_q  <= '0;
        row_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (accept) begin
              we_q   <= 4'b0001 << bank_q;
              data_q <= {iSAMPLE, {C_PAD{1'b0}}};
              addr_q <= row_q;
              bank_q <= bank_d;
              row_q  <= row_d;
              if (last_smp) state_q <= S_KICK;
            end
          end
          S_KICK: begin
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            // Only a fresh rising edge of the FHT ready releases the loader.
            if (iFHT_RDY && !rdy_q) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b0;
              bank_q  <= '0;
              row_q   <= '0;
            end
          end
          default: state_q <= S_LOAD;
        endcase
      end
    end
  end

  assign oWE    = we_q;
  assign oDATA  = data_q;
  assign oADDR  = addr_q;
  assign oSTART = start_q;
  assign oBUSY  = busy_q;

`ifdef FHT_LOADER_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      drop_q <= '0;
    end else if (iCLR) begin
      drop_q <= '0;
    end else if (iVALID && !oREADY && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign oDROP_CNT = drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fht_adc_loader.sv
`default_nettype none
// tb_fht_adc_loader : directed + randomized bench with a frame-level reference model.
module tb_fht_adc_loader;

  localparam int ADC_WIDTH = 12;
  localparam int D_BIT     = 22;
  localparam int A_BIT     = 2;
  localparam int FRAME     = 4 * (1 << A_BIT);

  logic                 clk = 1'b0;
  logic                 iRESET, iCLR, iVALID, iFHT_RDY;
  logic [ADC_WIDTH-1:0] iSAMPLE;
  logic                 oREADY, oSTART, oBUSY;
  logic [3:0]           oWE;
  logic [D_BIT-1:0]     oDATA;
  logic [A_BIT-1:0]     oADDR;
`ifdef FHT_LOADER_DROP_CNT_EN
  logic [15:0]          oDROP_CNT;
`endif

  always #5 clk = ~clk;

  fht_adc_loader #(.ADC_WIDTH(ADC_WIDTH), .D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK     (clk),
    .iRESET   (iRESET),
    .iCLR     (iCLR),
    .iVALID   (iVALID),
    .iSAMPLE  (iSAMPLE),
    .oREADY   (oREADY),
    .oWE      (oWE),
    .oDATA    (oDATA),
    .oADDR    (oADDR),
    .oSTART   (oSTART),
    .iFHT_RDY (iFHT_RDY),
    .oBUSY    (oBUSY)
`ifdef FHT_LOADER_DROP_CNT_EN
    ,
    .oDROP_CNT(oDROP_CNT)
`endif
  );

  int checks = 0;
  int errors = 0;
  int nstart = 0;

  // Reference model: accepted-sample index within the frame determines bank/row.
  int               m_k;
  bit               m_full;
  bit               m_busy;
  bit               m_prev_rdy;
  int               m_drops;
  logic [3:0]       e_we;
  logic [D_BIT-1:0] e_data;
  logic [A_BIT-1:0] e_addr;
  bit               e_start;
  bit               drv_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_full = 0; m_busy = 0; m_drops = 0;
    e_we = '0; e_data = '0; e_addr = '0; e_start = 0;
  endtask

  task automatic step(input bit valid, input logic [ADC_WIDTH-1:0] smp, input bit clr);
    bit ready;
    int s;
    iVALID = valid; iSAMPLE = smp; iCLR = clr; iFHT_RDY = drv_rdy;
    ready   = !m_full && !m_busy;
    e_we    = '0;
    e_start = 0;
    if (clr) begin
      m_k = 0; m_full = 0; m_busy = 0; m_drops = 0;
    end else begin
      if (valid && !ready && m_drops < 65535) m_drops++;
      if (m_busy) begin
        if (drv_rdy && !m_prev_rdy) m_busy = 0;
      end else if (m_full) begin
        e_start = 1; m_busy = 1; m_full = 0;
      end else if (valid) begin
        s      = $signed(smp);
        e_we   = 4'(1 << (m_k % 4));
        e_addr = A_BIT'(m_k / 4);
        e_data = D_BIT'(s * (1 << (D_BIT - ADC_WIDTH)));
        m_k++;
        if (m_k == FRAME) begin
          m_k = 0; m_full = 1;
        end
      end
    end
    m_prev_rdy = drv_rdy;
    @(posedge clk); #1;
    check("we",    oWE,    e_we);
    check("addr",  oADDR,  e_addr);
    check("data",  oDATA,  e_data);
    check("start", oSTART, e_start);
    check("busy",  oBUSY,  m_busy);
    check("ready", oREADY, !m_full && !m_busy);
`ifdef FHT_LOADER_DROP_CNT_EN
    check("drop",  oDROP_CNT, m_drops);
`endif
    if (oSTART === 1'b1) nstart++;
  endtask

  task automatic do_reset();
    iVALID = 0; iCLR = 0;
    #2 iRESET = 0;
    #1;
    model_reset();
    check("rst_we",    oWE,    0);
    check("rst_data",  oDATA,  0);
    check("rst_addr",  oADDR,  0);
    check("rst_start", oSTART, 0);
    check("rst_busy",  oBUSY,  0);
    @(negedge clk) iRESET = 1;
    @(posedge clk); #1;
    m_prev_rdy = drv_rdy;
    check("rst_ready", oREADY, 1);
  endtask

  task automatic release_fht();
    drv_rdy = 0; step(0, '0, 0);
    drv_rdy = 1; step(0, '0, 0);
    drv_rdy = 0; step(0, '0, 0);
  endtask

  task automatic send_random(input int n, input bit gaps);
    int acc = 0;
    for (int g = 0; g < 400 && acc < n; g++) begin
      bit v;
      v = gaps ? bit'($urandom_range(1, 0)) : 1'b1;
      step(v, ADC_WIDTH'($urandom), 0);
      if (v) acc++;
    end
  endtask

  initial begin
    iRESET = 0; iCLR = 0; iVALID = 0; iSAMPLE = '0; drv_rdy = 0; iFHT_RDY = 0;
    m_prev_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_we",    oWE,    0);
    check("init_data",  oDATA,  0);
    check("init_addr",  oADDR,  0);
    check("init_start", oSTART, 0);
    check("init_busy",  oBUSY,  0);
    @(negedge clk) iRESET = 1;
    @(posedge clk); #1;
    check("init_ready", oREADY, 1);

    // Frame A: 1..16 back-to-back; FHT ready goes high before start.
    nstart = 0;
    for (int i = 1; i <= FRAME; i++) begin
      if (i == FRAME) drv_rdy = 1;
      step(1, ADC_WIDTH'(i), 0);
      if (i == 5) begin
        check("s5_data", oDATA, 22'h001400);
        check("s5_we",   oWE,   4'b0001);
        check("s5_addr", oADDR, 1);
      end
    end
    step(0, '0, 0);
    check("a_start_once", nstart, 1);
    for (int i = 0; i < 3; i++) step(1, ADC_WIDTH'($urandom), 0);
    check("a_busy_hold", oBUSY, 1);
`ifdef FHT_LOADER_DROP_CNT_EN
    check("a_drop3", oDROP_CNT, 3);
`endif
    step(0, '0, 0);
    check("a_start_total", nstart, 1);
    release_fht();

    // Frame B: extreme values then random data with ~50% valid gaps.
    nstart = 0;
    step(1, 12'hFFF, 0);
    check("neg1_data", oDATA, 22'h3FFC00);
    check("neg1_we",   oWE,   4'b0001);
    check("neg1_addr", oADDR, 0);
    step(1, 12'h800, 0);
    check("min_data", oDATA, 22'h200000);
    send_random(FRAME - 2, 1);
    step(0, '0, 0);
    step(0, '0, 0);
    check("b_start_once", nstart, 1);
    release_fht();

    // Frame C: asynchronous reset after 7 samples, then a clean frame.
    for (int i = 0; i < 7; i++) step(1, ADC_WIDTH'($urandom), 0);
    do_reset();
    nstart = 0;
    step(1, 12'h123, 0);
    check("c_first_we",   oWE,   4'b0001);
    check("c_first_addr", oADDR, 0);
    send_random(FRAME - 1, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    check("c_start_once", nstart, 1);
    release_fht();

    // Frame D: abort after 9 samples with a sample on the iCLR cycle.
    for (int i = 0; i < 9; i++) step(1, ADC_WIDTH'($urandom), 0);
    step(1, 12'h7FF, 1);
    check("clr_no_we", oWE, 0);
    nstart = 0;
    step(1, 12'h456, 0);
    check("d_first_we",   oWE,   4'b0001);
    check("d_first_addr", oADDR, 0);
    send_random(FRAME - 1, 1);
    step(0, '0, 0);
    step(0, '0, 0);
    check("d_start_once", nstart, 1);
    release_fht();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fht_adc_loader.md
Name: fht_adc_loader

Overview:
- Upstream feeder for fht_top: accepts a streaming ADC sample interface and converts each sample to the FHT fixed-point format.
- Distributes samples round-robin over the 4 RAM bank write ports (bank 0..3, then next row address), matching the FHT's row-by-row input order.
- After a full frame of 4*2^A_BIT samples, issues a one-cycle start pulse to fht_top, then blocks further loading until fht_top signals ready.

Parameters:
ADC_WIDTH, 12, ADC sample width (signed, two's complement)
D_BIT, 22, FHT data width; must be > ADC_WIDTH
A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT rows

Ports:
iCLK  in  1  clock; single clock domain
iRESET  in  1  asynchronous, active-low reset
iCLR  in  1  synchronous abort: drop the partial frame and return to LOAD
iVALID  in  1  ADC sample valid
iSAMPLE  in  ADC_WIDTH  signed ADC sample
oREADY  out  1  loader accepts a sample this cycle (high only in LOAD)
oWE  out  4  one-hot bank write enable, to fht_top iWE
oDATA  out  D_BIT  fixed-point data, to iDATA_0..3
oADDR  out  A_BIT  row address, to iADDR_WR_0..3
oSTART  out  1  one-cycle start pulse, to fht_top iSTART
iFHT_RDY  in  1  fht_top oRDY
oBUSY  out  1  frame loaded; waiting for FHT completion

Behaviour:
- Reset (iRESET=0, async): oWE=0, oDATA=0, oADDR=0, oSTART=0, oBUSY=0, internal bank counter=0, row counter=0, state=LOAD. oREADY=1 once reset is released.
- States:
  - LOAD: oREADY=1.
  - KICK: one cycle.
  - WAIT: oBUSY=1, oREADY=0.
- Accept: a sample is accepted when iVALID & oREADY at a clock edge.
- Write latency: 1 cycle. In the cycle after acceptance, oWE has the bit for the current bank set, oADDR=row, oDATA={iSAMPLE, (D_BIT-ADC_WIDTH) zeros}. All three outputs are registered. oWE=0 in any cycle with no accepted sample in the previous cycle; oDATA/oADDR hold their last value.
- Counters:
  - Bank counter increments 0→1→2→3→0 on each accept.
  - Row counter increments when the bank counter wraps 3→0.
  - Row wraps from BANK_SIZE-1 to 0 at end of frame.
- Gaps: iVALID gaps are allowed anywhere in a frame. Counters hold; no write is issued.
- Last sample (bank 3, row BANK_SIZE-1) accepted at edge T:
  - Write appears at T+1.
  - State goes LOAD→KICK at T+1.
  - oSTART=1 for exactly the cycle after T+1, i.e. one cycle after the last oWE.
  - State then goes KICK→WAIT.
- WAIT:
  - A registered edge detector on iFHT_RDY exits WAIT on the first 0→1 transition of iFHT_RDY observed after oSTART.
  - A level already high at entry does not count; a fresh rising edge is required.
  - On exit: WAIT→LOAD, oBUSY=0, counters at 0.
- Samples presented while oREADY=0 are dropped; no write is issued.
- iCLR has priority over all other events:
  - Next edge: state=LOAD, counters=0, oWE=0, oSTART=0, oBUSY=0.
  - A sample presented in the same cycle as iCLR is not accepted.
- Reset mid-frame: all state is lost. The next frame starts at bank 0, row 0.
- No arithmetic saturation. The fixed-point conversion is a pure left shift by D_BIT-ADC_WIDTH, and the sign is preserved by the MSB placement.

Optional Feature:
- Macro: FHT_LOADER_DROP_CNT_EN.
- When defined:
  - Adds output oDROP_CNT (16 bits): counts cycles with iVALID=1 & oREADY=0.
  - Saturates at 0xFFFF.
  - Cleared by reset and by iCLR.
  - Not cleared at the start of a new frame.
- When undefined: no port, no counter logic.

Test Plan:
- A_BIT=2, samples 1..16 back-to-back → oWE sequence 0001,0010,0100,1000 at oADDR 0, repeating for oADDR 1,2,3. Sample 5 gives oDATA=5<<10=0x001400 at bank 0, addr 1. oSTART is high for exactly 1 cycle, one cycle after the 16th write.
- iSAMPLE=-1 (0xFFF) and -2048 (0x800) → oDATA=0x3FFC00 and 0x200000.
- After oSTART, hold iFHT_RDY=1, then present 3 valid samples → no oWE, oBUSY=1, oREADY=0. Then drive iFHT_RDY 0→1 → oBUSY falls; the next sample is written to bank 0, addr 0. With FHT_LOADER_DROP_CNT_EN defined, oDROP_CNT=3.
- Random iVALID gaps (≈50% duty) over a full frame → same bank/addr/data sequence as the back-to-back case; exactly one oSTART.
- Pulse iRESET low asynchronously after 7 samples → all outputs 0 immediately. Re-send 16 samples → first write at bank 0, addr 0; one oSTART.
- Assert iCLR after 9 samples, with iVALID=1 in the same cycle → that sample is not written. The following frame starts at bank 0, addr 0.
